// File: rtl/sched_pkg.sv
// ============================================================================
// sched_pkg : shared task-class, core-state and width definitions
// Rev 1.0
// ============================================================================
`default_nettype none

package sched_pkg;

  localparam int TASK_W    = 32;
  localparam int PAYLOAD_W = 30;
  localparam int CORE_A    = 0;
  localparam int CORE_B    = 1;

  typedef enum logic [1:0] {
    CLS_SCALAR  = 2'b00,
    CLS_MATRIX  = 2'b01,
    CLS_ANY     = 2'b10,
    CLS_ILLEGAL = 2'b11
  } task_class_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  function automatic task_class_e task_class(input logic [TASK_W-1:0] t);
    return task_class_e'(t[TASK_W-1 -: 2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sched_fifo.sv
// ============================================================================
// sched_fifo : power-of-two circular task queue with occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module sched_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/core_task_scheduler.sv
// ============================================================================
// core_task_scheduler : in-order task queue dispatching to scalar/matrix cores
// Define SCHEDULER_WATCHDOG_EN for a per-core busy watchdog.       Rev 1.0
// ============================================================================
`default_nettype none

module core_task_scheduler
  import sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WDT_LIMIT  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 task_valid,
  input  logic [TASK_W-1:0]    task_data,
  output logic                 task_ready,
  output logic                 core_a_req,
  output logic [PAYLOAD_W-1:0] core_a_task,
  input  logic                 core_a_ack,
  input  logic                 core_a_done,
  output logic                 core_a_timeout,
  output logic                 core_b_req,
  output logic [PAYLOAD_W-1:0] core_b_task,
  input  logic                 core_b_ack,
  input  logic                 core_b_done,
  output logic                 core_b_timeout,
  output logic                 err_illegal,
  output logic [4:0]           queue_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      WDT_LIMIT < 1) begin : g_bad_params
    $error("core_task_scheduler: unsupported FIFO_DEPTH or WDT_LIMIT");
  end

  task_class_e          w_in_cls;
  task_class_e          w_head_cls;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [TASK_W-1:0]    w_head;
  logic [CNT_W-1:0]     w_count;
  logic                 w_full;
  logic                 w_empty;
  logic [1:0]           w_idle;
  logic [1:0]           w_dispatch;
  logic [1:0]           w_req;
  logic [1:0]           w_timeout;
  logic [1:0]           w_ack;
  logic [1:0]           w_done;
  logic [PAYLOAD_W-1:0] w_task [2];
  logic                 r_rr;
  logic                 r_err;

  assign w_in_cls = task_class(task_data);
  assign w_accept = task_valid & task_ready;
  assign w_push   = w_accept & (w_in_cls != CLS_ILLEGAL);
  assign w_ack    = {core_b_ack, core_a_ack};
  assign w_done   = {core_b_done, core_a_done};

  sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TASK_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (task_data),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_head_cls = task_class(w_head);

  // Only the head may leave; if its core is unavailable everything behind waits.
  always_comb begin
    w_dispatch = '0;
    if (!w_empty) begin
      case (w_head_cls)
        CLS_SCALAR: w_dispatch[CORE_A] = w_idle[CORE_A];
        CLS_MATRIX: w_dispatch[CORE_B] = w_idle[CORE_B];
        CLS_ANY: begin
          if (&w_idle) w_dispatch[r_rr] = 1'b1;
          else         w_dispatch = w_idle;
        end
        default: w_dispatch = '0;
      endcase
    end
  end

  assign w_pop = |w_dispatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_rr  <= r_rr ^ (w_pop & (w_head_cls == CLS_ANY));
      r_err <= w_accept & (w_in_cls == CLS_ILLEGAL);
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_core
    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic                 w_expire;
    logic                 w_is_req;
    logic                 w_is_idle;
    logic                 w_to;
    logic [PAYLOAD_W-1:0] r_task;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        ST_IDLE: if (w_dispatch[i]) w_next = ST_REQ;
        ST_REQ:  if (w_ack[i])      w_next = ST_BUSY;
        ST_BUSY: if (w_done[i] || w_expire) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end

    always_comb begin
      w_is_req  = (r_state == ST_REQ);
      w_is_idle = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             r_task <= '0;
      else if (w_dispatch[i]) r_task <= w_head[PAYLOAD_W-1:0];
    end

`ifdef SCHEDULER_WATCHDOG_EN
    localparam int WDT_W = (WDT_LIMIT > 1) ? $clog2(WDT_LIMIT) : 1;
    logic [WDT_W-1:0] r_wdt;
    logic             r_timeout;

    // Counter sits at zero outside BUSY so every task starts a fresh budget.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wdt     <= '0;
        r_timeout <= 1'b0;
      end else begin
        r_wdt     <= (r_state == ST_BUSY) ? r_wdt + 1'b1 : '0;
        r_timeout <= w_expire & ~w_done[i];
      end
    end

    assign w_expire = (r_state == ST_BUSY) && (r_wdt == WDT_W'(WDT_LIMIT - 1));
    assign w_to     = r_timeout;
`else
    assign w_expire = 1'b0;
    assign w_to     = 1'b0;
`endif

    assign w_req[i]     = w_is_req;
    assign w_idle[i]    = w_is_idle;
    assign w_timeout[i] = w_to;
    assign w_task[i]    = r_task;
  end

  assign task_ready     = ~w_full;
  assign queue_count    = 5'(w_count);
  assign err_illegal    = r_err;
  assign core_a_req     = w_req[CORE_A];
  assign core_b_req     = w_req[CORE_B];
  assign core_a_task    = w_task[CORE_A];
  assign core_b_task    = w_task[CORE_B];
  assign core_a_timeout = w_timeout[CORE_A];
  assign core_b_timeout = w_timeout[CORE_B];

endmodule

`default_nettype wire

// File: tb/tb_core_task_scheduler.sv
// ============================================================================
// tb_core_task_scheduler : directed stimulus, queue-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_task_scheduler;

  localparam int DEPTH = 4;
  localparam int WDT   = 8;
`ifdef SCHEDULER_WATCHDOG_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        task_valid = 1'b0;
  logic [31:0] task_data = '0;
  logic        task_ready;
  logic        core_a_req, core_b_req;
  logic [29:0] core_a_task, core_b_task;
  logic        core_a_ack = 1'b0, core_b_ack = 1'b0;
  logic        core_a_done = 1'b0, core_b_done = 1'b0;
  logic        core_a_timeout, core_b_timeout;
  logic        err_illegal;
  logic [4:0]  queue_count;

  core_task_scheduler #(.FIFO_DEPTH(DEPTH), .WDT_LIMIT(WDT)) dut (
    .clk(clk), .rst_n(rst_n),
    .task_valid(task_valid), .task_data(task_data), .task_ready(task_ready),
    .core_a_req(core_a_req), .core_a_task(core_a_task), .core_a_ack(core_a_ack),
    .core_a_done(core_a_done), .core_a_timeout(core_a_timeout),
    .core_b_req(core_b_req), .core_b_task(core_b_task), .core_b_ack(core_b_ack),
    .core_b_done(core_b_done), .core_b_timeout(core_b_timeout),
    .err_illegal(err_illegal), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain task list plus per-core "requesting"/"working" flags.
  logic [31:0] mq[$];
  bit          m_req[2];
  bit          m_busy[2];
  int          m_age[2];
  logic [29:0] m_task[2];
  bit          m_to[2];
  bit          m_rr;
  bit          m_err;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 0; m_busy[i] = 0; m_age[i] = 0; m_task[i] = '0; m_to[i] = 0;
    end
    m_rr = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit          idle[2];
    bit          disp[2];
    bit          ack[2];
    bit          done[2];
    logic [31:0] head;
    int          size_before;
    head = '0;
    ack[0] = core_a_ack;   ack[1] = core_b_ack;
    done[0] = core_a_done; done[1] = core_b_done;
    size_before = mq.size();
    for (int i = 0; i < 2; i++) begin
      idle[i] = !m_req[i] && !m_busy[i];
      disp[i] = 0;
    end
    if (size_before > 0) begin
      head = mq[0];
      if (head[31:30] == 2'b00) disp[0] = idle[0];
      else if (head[31:30] == 2'b01) disp[1] = idle[1];
      else if (head[31:30] == 2'b10) begin
        if (idle[0] && idle[1]) disp[m_rr] = 1;
        else if (idle[0]) disp[0] = 1;
        else if (idle[1]) disp[1] = 1;
      end
    end
    for (int i = 0; i < 2; i++) begin
      m_to[i] = 0;
      if (m_req[i] && ack[i]) begin
        m_req[i] = 0; m_busy[i] = 1; m_age[i] = 0;
      end else if (m_busy[i]) begin
        if (done[i]) m_busy[i] = 0;
        else if (WDT_ON) begin
          m_age[i]++;
          if (m_age[i] == WDT) begin m_busy[i] = 0; m_to[i] = 1; end
        end
      end
      if (disp[i]) begin m_req[i] = 1; m_task[i] = head[29:0]; end
    end
    if (disp[0] || disp[1]) begin
      void'(mq.pop_front());
      if (head[31:30] == 2'b10) m_rr = !m_rr;
    end
    m_err = 0;
    if (task_valid && size_before < DEPTH) begin
      if (task_data[31:30] == 2'b11) m_err = 1;
      else mq.push_back(task_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic push(input logic [1:0] cls, input logic [29:0] pl);
    task_valid = 1'b1;
    task_data  = {cls, pl};
    tick();
    task_valid = 1'b0;
  endtask

  task automatic serve_a(input logic [29:0] pl);
    for (int k = 0; k < 10 && !core_a_req; k++) tick();
    check("serve_a_req_seen", core_a_req, 1);
    check("serve_a_task", core_a_task, pl);
    core_a_ack = 1'b1; tick(); core_a_ack = 1'b0;
    core_a_done = 1'b1; tick(); core_a_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, task_ready, 1);
    check({tag, "_count"}, queue_count, 0);
    check({tag, "_reqs"}, {core_a_req, core_b_req}, 0);
    check({tag, "_tasks"}, core_a_task | core_b_task, 0);
    check({tag, "_flags"}, {err_illegal, core_a_timeout, core_b_timeout}, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", task_ready, mq.size() < DEPTH);
      check("m_count", queue_count, mq.size());
      check("m_a_req", core_a_req, m_req[0]);
      check("m_b_req", core_b_req, m_req[1]);
      if (m_req[0]) check("m_a_task", core_a_task, m_task[0]);
      if (m_req[1]) check("m_b_task", core_b_task, m_task[1]);
      check("m_err", err_illegal, m_err);
      check("m_a_to", core_a_timeout, m_to[0]);
      check("m_b_to", core_b_timeout, m_to[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    model_reset();
    tick(); tick();
    chk_en = 1'b1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single class-00 task: one cycle from write to req.
    push(2'b00, 30'h5);
    check("a_latency_q", queue_count, 1);
    check("a_latency_req0", core_a_req, 0);
    tick();
    check("a_req", core_a_req, 1);
    check("a_task", core_a_task, 30'h5);
    check("a_popped", queue_count, 0);
    core_a_ack = 1'b1; tick(); core_a_ack = 1'b0;
    check("a_req_after_ack", core_a_req, 0);
    core_b_done = 1'b1; tick(); core_b_done = 1'b0;
    core_a_ack = 1'b1; tick(); core_a_ack = 1'b0;
    core_a_done = 1'b1; tick(); core_a_done = 1'b0;
    tick();

    // Class-10 round robin.
    push(2'b10, 30'h11);
    push(2'b10, 30'h22);
    check("rr_first_a", core_a_req, 1);
    check("rr_first_task", core_a_task, 30'h11);
    check("rr_first_b_idle", core_b_req, 0);
    tick();
    check("rr_second_b", core_b_req, 1);
    check("rr_second_task", core_b_task, 30'h22);
    core_a_ack = 1'b1; core_b_ack = 1'b1; tick(); core_a_ack = 1'b0; core_b_ack = 1'b0;
    core_a_done = 1'b1; core_b_done = 1'b1; tick(); core_a_done = 1'b0; core_b_done = 1'b0;
    push(2'b10, 30'h33);
    tick();
    check("rr_back_to_a", core_a_req, 1);
    check("rr_back_b_idle", core_b_req, 0);
    serve_a(30'h33);

    // Head-of-line blocking behind a busy core A.
    push(2'b00, 30'h1);
    tick();
    core_a_ack = 1'b1; tick(); core_a_ack = 1'b0;
    push(2'b00, 30'h2);
    push(2'b01, 30'h3);
    tick(); tick();
    check("hol_b_blocked", core_b_req, 0);
    check("hol_count", queue_count, 2);
    core_a_done = 1'b1; tick(); core_a_done = 1'b0;
    check("hol_a_idle", core_a_req, 0);
    tick();
    check("hol_a_req", core_a_req, 1);
    check("hol_a_task", core_a_task, 30'h2);
    check("hol_b_still", core_b_req, 0);
    tick();
    check("hol_b_req", core_b_req, 1);
    check("hol_b_task", core_b_task, 30'h3);
    core_a_ack = 1'b1; core_b_ack = 1'b1; tick(); core_a_ack = 1'b0; core_b_ack = 1'b0;
    core_a_done = 1'b1; core_b_done = 1'b1; tick(); core_a_done = 1'b0; core_b_done = 1'b0;
    tick();

    // Fill the queue while core A waits for ack, then drain across the wrap.
    push(2'b00, 30'h40);
    push(2'b00, 30'h41);
    push(2'b00, 30'h42);
    push(2'b00, 30'h43);
    push(2'b00, 30'h44);
    check("full_count", queue_count, 4);
    check("full_ready", task_ready, 0);
    push(2'b00, 30'h4F);
    check("full_reject", queue_count, 4);
    serve_a(30'h40);
    serve_a(30'h41);
    push(2'b00, 30'h45);
    check("pushpop_count", queue_count, 3);
    check("pushpop_task", core_a_task, 30'h42);
    serve_a(30'h42);
    serve_a(30'h43);
    serve_a(30'h44);
    serve_a(30'h45);
    tick(); tick();
    check("drain_count", queue_count, 0);
    check("drain_no_extra", core_a_req, 0);

    // Illegal class.
    push(2'b11, 30'h7);
    check("illegal_err", err_illegal, 1);
    check("illegal_count", queue_count, 0);
    tick();
    check("illegal_err_clear", err_illegal, 0);

    // Busy core A without done.
    push(2'b00, 30'h9);
    tick();
    core_a_ack = 1'b1; tick(); core_a_ack = 1'b0;
`ifdef SCHEDULER_WATCHDOG_EN
    for (int k = 1; k < WDT; k++) begin
      tick();
      check("wdt_quiet", core_a_timeout, 0);
    end
    tick();
    check("wdt_pulse", core_a_timeout, 1);
    tick();
    check("wdt_pulse_end", core_a_timeout, 0);
    push(2'b00, 30'hA);
    tick();
    check("wdt_idle_again", core_a_req, 1);
    check("wdt_idle_task", core_a_task, 30'hA);
    serve_a(30'hA);
`else
    for (int k = 0; k < WDT + 4; k++) tick();
    check("no_wdt_timeout", core_a_timeout, 0);
    core_a_done = 1'b1; tick(); core_a_done = 1'b0;
`endif

    // Reset in the middle of activity.
    push(2'b01, 30'hB);
    tick();
    core_b_ack = 1'b1; tick(); core_b_ack = 1'b0;
    push(2'b00, 30'hC);
    push(2'b01, 30'hD);
    tick();
    check("pre_rst_a_req", core_a_req, 1);
    check("pre_rst_count", queue_count, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    push(2'b10, 30'hE);
    tick();
    check("post_rst_rr_a", core_a_req, 1);
    check("post_rst_task", core_a_task, 30'hE);
    check("post_rst_b", core_b_req, 0);
    serve_a(30'hE);
    tick(); tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/core_task_scheduler.md
CORE_TASK_SCHEDULER -- requirements
Module: core_task_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the task queue depth (power of two, 2..16).
REQ-002 Parameter WDT_LIMIT, default 1024, SHALL set the watchdog cycle limit per dispatched task.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 task_valid  in  1  SHALL mark a task offered on task_data.
REQ-006 task_data  in  32  SHALL carry the task: [31:30] class (00 scalar/core A, 01 matrix/core B, 10 any, 11 illegal), [29:0] payload.
REQ-007 task_ready  out  1  SHALL be high when the queue is not full; a task is accepted when task_valid and task_ready are both high.
REQ-008 core_a_req, core_b_req  out  1  SHALL request the core to start the presented task.
REQ-009 core_a_task, core_b_task  out  30  SHALL carry the payload; held stable while req is high.
REQ-010 core_a_ack, core_b_ack  in  1  SHALL acknowledge the request.
REQ-011 core_a_done, core_b_done  in  1  SHALL be one-cycle completion pulses.
REQ-012 core_a_timeout, core_b_timeout  out  1  SHALL be one-cycle watchdog pulses.
REQ-013 err_illegal  out  1  SHALL be a one-cycle pulse for a discarded class-11 task.
REQ-014 queue_count  out  5  SHALL report queue occupancy.

Function
REQ-015 Per-core FSM SHALL be IDLE -> REQ (dispatch) -> BUSY (ack) -> IDLE (done or timeout).
REQ-016 core_x_req SHALL be high exactly in REQ; done SHALL be ignored outside BUSY; ack SHALL be ignored outside REQ.
REQ-017 Dispatch SHALL be strictly in order from the queue head, with at most one pop per cycle; a non-dispatchable head blocks later tasks.
REQ-018 Class 00 head SHALL dispatch only to an IDLE core A; class 01 head only to an IDLE core B.
REQ-019 Class 10 head SHALL go to the only IDLE core if exactly one is IDLE, or to the core selected by a round-robin pointer if both are IDLE; the pointer then toggles.
REQ-020 A task written into an empty queue with its target core IDLE SHALL raise req at the next clock edge (1-cycle latency).
REQ-021 A core entering IDLE SHALL be eligible for dispatch in the following cycle.
REQ-022 A class-11 task SHALL be accepted but not stored, and SHALL raise err_illegal on the next cycle.
REQ-023 A simultaneous push and pop SHALL leave queue_count unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 Reset assertion SHALL, at any time including mid-task, force: both FSMs to IDLE, the queue empty, the round-robin pointer to A, and all outputs to 0 except task_ready, which SHALL be 1 after reset.

Configuration
REQ-025 With SCHEDULER_WATCHDOG_EN defined, each BUSY core SHALL count cycles; reaching WDT_LIMIT without done SHALL return the core to IDLE and pulse core_x_timeout for one cycle.
REQ-026 Without SCHEDULER_WATCHDOG_EN, no counters SHALL exist and the timeout outputs SHALL be tied to 0.

Structure
REQ-027 Package sched_pkg SHALL hold the class encoding, the core FSM state encoding, and the payload width constant.
REQ-028 The queue SHALL be a sub-module sched_fifo (push, pop, count, full, empty).

Verification
REQ-029 Reset, then push class 00 payload 0x5 with core A idle -> core_a_req=1 next cycle with core_a_task=0x5; ack -> BUSY; done -> IDLE.
REQ-030 Push two class-10 tasks with both cores idle -> the first goes to A, the second to B; the pointer returns to A.
REQ-031 Core A busy, push class 00 then class 01 -> the class-01 task waits (head-of-line blocking) until A's done is seen, then A is dispatched and B follows next cycle.
REQ-032 Push 4 tasks with no dispatch possible -> queue_count=4 and task_ready=0; the fifth task_valid is not accepted.
REQ-033 Push class 11 -> err_illegal pulses once and queue_count stays 0.
REQ-034 With SCHEDULER_WATCHDOG_EN and WDT_LIMIT=8, withhold done -> core_a_timeout pulses 8 cycles after entering BUSY and core A returns to IDLE; assert rst_n low mid-BUSY -> all outputs return to reset values.
